// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state and execute-class enumerations for the
// multi-cycle control unit.
package cpu_pkg;

  localparam logic [4:0] OP_LD     = 5'b00000;
  localparam logic [4:0] OP_LDI    = 5'b00001;
  localparam logic [4:0] OP_ST     = 5'b00010;
  localparam logic [4:0] OP_ALU_LO = 5'b00011;
  localparam logic [4:0] OP_ALU_HI = 5'b01011;
  localparam logic [4:0] OP_ADDI   = 5'b01100;
  localparam logic [4:0] OP_ANDI   = 5'b01101;
  localparam logic [4:0] OP_ORI    = 5'b01110;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_NEG    = 5'b10001;
  localparam logic [4:0] OP_NOT    = 5'b10010;
  localparam logic [4:0] OP_BR     = 5'b10011;
  localparam logic [4:0] OP_JR     = 5'b10100;
  localparam logic [4:0] OP_IN     = 5'b10110;
  localparam logic [4:0] OP_OUT    = 5'b10111;
  localparam logic [4:0] OP_MFHI   = 5'b11000;
  localparam logic [4:0] OP_MFLO   = 5'b11001;
  localparam logic [4:0] OP_NOP    = 5'b11010;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_IMM, CL_LDI, CL_MULDIV, CL_UNARY, CL_LD, CL_ST,
    CL_BR, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
  } op_class_e;

  // Field order matches the port concatenation in the top module.
  typedef struct packed {
    logic run, en_out, inport_out, con_in, c_out, ba_out, r_out, r_in;
    logic grc, grb, gra, lo_out, hi_out, lo_in, hi_in, zlow_out, zhigh_out;
    logic zlo_in, zhi_in, y_in, ir_in, ram_wr, read, mdr_out, mdr_in;
    logic mar_in, inc_pc, pc_in, pc_out;
  } ctl_t;

  // Last execute step of each class; that step hands back to fetch or halt.
  function automatic state_e last_step(op_class_e c);
    case (c)
      CL_ALU, CL_IMM, CL_LDI: return S_T5;
      CL_MULDIV, CL_BR:       return S_T6;
      CL_UNARY:               return S_T4;
      CL_LD, CL_ST:           return S_T7;
      default:                return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Maps a 5-bit opcode to its execute-sequence class; undefined opcodes act as nop.
module op_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CL_NOP;
    if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) op_class = CL_ALU;
    else begin
      case (opcode)
        OP_LD:                   op_class = CL_LD;
        OP_LDI:                  op_class = CL_LDI;
        OP_ST:                   op_class = CL_ST;
        OP_ADDI, OP_ANDI, OP_ORI: op_class = CL_IMM;
        OP_MUL, OP_DIV:          op_class = CL_MULDIV;
        OP_NEG, OP_NOT:          op_class = CL_UNARY;
        OP_BR:                   op_class = CL_BR;
        OP_JR:                   op_class = CL_JR;
        OP_IN:                   op_class = CL_IN;
        OP_OUT:                  op_class = CL_OUT;
        OP_MFHI:                 op_class = CL_MFHI;
        OP_MFLO:                 op_class = CL_MFLO;
        OP_HALT:                 op_class = CL_HALT;
        default:                 op_class = CL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: three fetch states, up to five execute steps selected by the
// class latched when leaving FETCH2, and an absorbing HALT.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout, PCin, IncPC,
  output logic        MARin, MDRin, MDRout, Read, RAM_wr_enable,
  output logic        IRin, Yin, ZHIin, ZLOin, ZHighout, ZLowout,
  output logic        HIin, LOin, HIout, LOout,
  output logic        GRA, GRB, GRC, R_in, R_out, Baout, Cout, CONin,
  output logic        InPortout, enable_outPort,
  output logic        Run
);

  state_e    state_q, state_d;
  op_class_e cls_q, cls_d, cls_dec;
  ctl_t      c;
  logic      unused_ir;

  assign unused_ir = ^IR[26:0];

  op_class_decode u_dec (.opcode(IR[31:27]), .op_class(cls_dec));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: begin
        // IR is sampled only here; later changes cannot redirect the sequence.
        cls_d = cls_dec;
        case (cls_dec)
          CL_HALT: state_d = S_HALT;
          CL_NOP:  state_d = stop ? S_HALT : S_FETCH0;
          default: state_d = S_T3;
        endcase
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == last_step(cls_q)) state_d = stop ? S_HALT : S_FETCH0;
        else begin
          case (state_q)
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            default: state_d = S_T7;
          endcase
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RESET;
      cls_q   <= CL_NOP;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; end
      S_FETCH1: begin c.read = 1'b1; c.mdr_in = 1'b1; end
      S_FETCH2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin
        case (cls_q)
          CL_ALU:    begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          CL_IMM:    begin c.grb = 1'b1; c.ba_out = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
          CL_MULDIV: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          CL_UNARY:  begin c.grb = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; end
          CL_BR:     begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
          CL_JR:     begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          CL_IN:     begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CL_OUT:    begin c.gra = 1'b1; c.r_out = 1'b1; c.en_out = 1'b1; end
          CL_MFHI:   begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CL_MFLO:   begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_q)
          CL_ALU:    begin c.grc = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; end
          CL_IMM, CL_LDI, CL_LD, CL_ST: begin c.c_out = 1'b1; c.zlo_in = 1'b1; end
          CL_MULDIV: begin c.grb = 1'b1; c.r_out = 1'b1; c.zhi_in = 1'b1; c.zlo_in = 1'b1; end
          CL_UNARY:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CL_BR:     begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls_q)
          CL_ALU, CL_IMM, CL_LDI: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CL_MULDIV:    begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
          CL_LD, CL_ST: begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
          CL_BR:        begin c.c_out = 1'b1; c.zlo_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls_q)
          CL_MULDIV: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
          CL_LD:     begin c.read = 1'b1; c.mdr_in = 1'b1; end
          CL_ST:     begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
          CL_BR:     begin c.zlow_out = CON_FF; c.pc_in = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls_q)
          CL_LD:   begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CL_ST:   c.ram_wr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    c.run = (state_q != S_RESET) && (state_q != S_HALT);
  end

  assign {Run, enable_outPort, InPortout, CONin, Cout, Baout, R_out, R_in,
          GRC, GRB, GRA, LOout, HIout, LOin, HIin, ZLowout, ZHighout,
          ZLOin, ZHIin, Yin, IRin, RAM_wr_enable, Read, MDRout, MDRin,
          MARin, IncPC, PCin, PCout} = c;

endmodule
